// File: rtl/rc5_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rc5_pkg : shared types and index helpers for the RC5 round engine   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package rc5_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int rot_bits(input int w);
    return $clog2(w);
  endfunction

  function automatic int table_words(input int max_rounds);
    return 2 * max_rounds + 2;
  endfunction

  function automatic int s_lo_idx(input int round);
    return 2 * round;
  endfunction

  function automatic int s_hi_idx(input int round);
    return 2 * round + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rc5_rot.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rc5_rot : combinational W-bit rotator, left or right by amt         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module rc5_rot
  import rc5_pkg::*;
#(
  parameter int W  = 16,
  parameter int RB = rot_bits(W)
) (
  input  logic [W-1:0]  data,
  input  logic [RB-1:0] amt,
  input  logic          dir,
  output logic [W-1:0]  result
);

  logic [2*W-1:0] w_dbl;
  logic [2*W-1:0] w_shl;
  logic [2*W-1:0] w_shr;

  // Shifting a doubled copy turns a rotate into a plain shift plus a slice.
  always_comb begin
    w_dbl  = {data, data};
    w_shl  = w_dbl << amt;
    w_shr  = w_dbl >> amt;
    result = dir ? w_shr[W-1:0] : w_shl[2*W-1:W];
  end

endmodule
`default_nettype wire

// File: rtl/rc5_round_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rc5_round_engine : iterative RC5 encrypt/decrypt, one round/clock   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module rc5_round_engine
  import rc5_pkg::*;
#(
  parameter int W          = 16,
  parameter int MAX_ROUNDS = 16,
  parameter int RW         = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          mode,
  input  logic [RW-1:0]                 num_rounds,
  input  logic [2*W-1:0]                d_in,
  input  logic [(2*MAX_ROUNDS+2)*W-1:0] subkeys,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*W-1:0]                d_out,
  output logic                          round_err
);

  localparam int            c_RB    = rot_bits(W);
  localparam int            c_T     = table_words(MAX_ROUNDS);
  localparam int            c_IW    = $clog2(c_T);
  localparam logic [RW-1:0] c_MAX_R = RW'(MAX_ROUNDS);
  localparam logic [RW-1:0] c_ONE   = RW'(1);

  state_t         r_state;
  logic           r_mode;
  logic           r_err;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_round_err;
  logic [RW-1:0]  r_count;
  logic [RW-1:0]  r_rounds;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] r_d_out;

  logic [W-1:0] w_s [c_T];

  for (genvar gi = 0; gi < c_T; gi++) begin : g_s_unpack
    assign w_s[gi] = subkeys[gi*W +: W];
  end

  // ---------------- accept path ----------------
  logic [W-1:0]  w_din_a;
  logic [W-1:0]  w_din_b;
  logic          w_accept;
  logic          w_req_err;
  logic [RW-1:0] w_req_rounds;
  logic          w_acc_done;
  logic [W-1:0]  w_acc_a;
  logic [W-1:0]  w_acc_b;

  always_comb begin
    w_din_a      = d_in[W-1:0];
    w_din_b      = d_in[2*W-1:W];
    w_accept     = in_valid & r_in_ready;
    w_req_err    = (num_rounds > c_MAX_R);
    w_req_rounds = w_req_err ? c_MAX_R : num_rounds;
    w_acc_done   = (w_req_rounds == '0);
    if (!mode) begin
      w_acc_a = w_din_a + w_s[0];
      w_acc_b = w_din_b + w_s[1];
    end else if (w_acc_done) begin
      w_acc_a = w_din_a - w_s[0];
      w_acc_b = w_din_b - w_s[1];
    end else begin
      w_acc_a = w_din_a;
      w_acc_b = w_din_b;
    end
  end

  // ---------------- round datapath ----------------
  // Encrypt computes A' then B'; decrypt computes B' then A'. The first
  // rotator always serves the first half-round so no path loops back.
  logic [c_IW-1:0] w_idx_lo;
  logic [c_IW-1:0] w_idx_hi;
  logic [W-1:0]    w_s_lo;
  logic [W-1:0]    w_s_hi;
  logic [W-1:0]    w_rot1_in;
  logic [c_RB-1:0] w_rot1_amt;
  logic [W-1:0]    w_rot1_out;
  logic [W-1:0]    w_rot2_in;
  logic [c_RB-1:0] w_rot2_amt;
  logic [W-1:0]    w_rot2_out;
  logic [W-1:0]    w_first;
  logic [W-1:0]    w_second;
  logic [W-1:0]    w_a_nxt;
  logic [W-1:0]    w_b_nxt;
  logic            w_last;

  always_comb begin
    w_idx_lo = c_IW'(s_lo_idx(int'(r_count)));
    w_idx_hi = c_IW'(s_hi_idx(int'(r_count)));
    w_s_lo   = w_s[w_idx_lo];
    w_s_hi   = w_s[w_idx_hi];
    if (!r_mode) begin
      w_rot1_in  = r_a ^ r_b;
      w_rot1_amt = r_b[c_RB-1:0];
    end else begin
      w_rot1_in  = r_b - w_s_hi;
      w_rot1_amt = r_a[c_RB-1:0];
    end
  end

  rc5_rot #(.W(W), .RB(c_RB)) u_rot_first (
    .data   (w_rot1_in),
    .amt    (w_rot1_amt),
    .dir    (r_mode),
    .result (w_rot1_out)
  );

  always_comb begin
    w_first = r_mode ? (w_rot1_out ^ r_a) : (w_rot1_out + w_s_lo);
    if (!r_mode) begin
      w_rot2_in = r_b ^ w_first;
    end else begin
      w_rot2_in = r_a - w_s_lo;
    end
    w_rot2_amt = w_first[c_RB-1:0];
  end

  rc5_rot #(.W(W), .RB(c_RB)) u_rot_second (
    .data   (w_rot2_in),
    .amt    (w_rot2_amt),
    .dir    (r_mode),
    .result (w_rot2_out)
  );

  always_comb begin
    w_second = r_mode ? (w_rot2_out ^ w_first) : (w_rot2_out + w_s_hi);
    w_last   = r_mode ? (r_count == c_ONE) : (r_count == r_rounds);
    if (!r_mode) begin
      w_a_nxt = w_first;
      w_b_nxt = w_second;
    end else if (w_last) begin
      // Output whitening folded into the last decrypt round.
      w_b_nxt = w_first - w_s[1];
      w_a_nxt = w_second - w_s[0];
    end else begin
      w_b_nxt = w_first;
      w_a_nxt = w_second;
    end
  end

  // ---------------- control ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_count     <= '0;
      r_rounds    <= '0;
      r_mode      <= 1'b0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_d_out     <= '0;
      r_round_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_mode     <= mode;
            r_rounds   <= w_req_rounds;
            r_err      <= w_req_err;
            r_a        <= w_acc_a;
            r_b        <= w_acc_b;
            r_count    <= mode ? w_req_rounds : c_ONE;
            if (w_acc_done) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_d_out     <= {w_acc_b, w_acc_a};
              r_round_err <= w_req_err;
            end else begin
              r_state <= ROUND;
            end
          end
        end
        ROUND: begin
          r_a <= w_a_nxt;
          r_b <= w_b_nxt;
          if (w_last) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_d_out     <= {w_b_nxt, w_a_nxt};
            r_round_err <= r_err;
          end else begin
            r_count <= r_mode ? (r_count - c_ONE) : (r_count + c_ONE);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_d_out     <= '0;
            r_round_err <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign d_out     = r_d_out;
  assign round_err = r_round_err;

endmodule
`default_nettype wire

// File: tb/tb_rc5_round_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rc5_round_engine : directed bench, W=32 and W=16 instances       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_rc5_round_engine;

  localparam int MAXR = 16;
  localparam int T    = 2 * MAXR + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       mode       = 1'b0;
  logic [4:0] num_rounds = 5'd0;
  logic       out_ready  = 1'b0;

  logic            in_valid32 = 1'b0;
  logic            in_ready32, out_valid32, round_err32;
  logic [63:0]     d_in32 = '0;
  logic [63:0]     d_out32;
  logic [T*32-1:0] subkeys32;

  logic            in_valid16 = 1'b0;
  logic            in_ready16, out_valid16, round_err16;
  logic [31:0]     d_in16 = '0;
  logic [31:0]     d_out16;
  logic [T*16-1:0] subkeys16;

  logic [63:0] s32 [T];
  logic [63:0] s16 [T];

  always_comb begin
    subkeys32 = '0;
    subkeys16 = '0;
    for (int k = 0; k < T; k++) begin
      subkeys32[k*32 +: 32] = s32[k][31:0];
      subkeys16[k*16 +: 16] = s16[k][15:0];
    end
  end

  rc5_round_engine #(.W(32), .MAX_ROUNDS(MAXR), .RW(5)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .mode(mode), .num_rounds(num_rounds), .d_in(d_in32), .subkeys(subkeys32),
    .out_valid(out_valid32), .out_ready(out_ready), .d_out(d_out32),
    .round_err(round_err32)
  );

  rc5_round_engine #(.W(16), .MAX_ROUNDS(MAXR), .RW(5)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .mode(mode), .num_rounds(num_rounds), .d_in(d_in16), .subkeys(subkeys16),
    .out_valid(out_valid16), .out_ready(out_ready), .d_out(d_out16),
    .round_err(round_err16)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] msk(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] rl(input logic [63:0] x, input logic [63:0] amt, input int w);
    int s;
    s = int'(amt % 64'(w));
    if (s == 0) return x & msk(w);
    return ((x << s) | (x >> (w - s))) & msk(w);
  endfunction

  function automatic logic [63:0] rr(input logic [63:0] x, input logic [63:0] amt, input int w);
    int s;
    s = int'(amt % 64'(w));
    if (s == 0) return x & msk(w);
    return ((x >> s) | (x << (w - s))) & msk(w);
  endfunction

  function automatic logic [63:0] sk(input int w, input int i);
    return (w == 32) ? s32[i] : s16[i];
  endfunction

  function automatic logic [63:0] model_enc(input int w, input int r, input logic [63:0] blk);
    logic [63:0] m, a, b;
    m = msk(w);
    a = (blk & m) + sk(w, 0);
    b = ((blk >> w) & m) + sk(w, 1);
    a = a & m;
    b = b & m;
    for (int i = 1; i <= r; i++) begin
      a = (rl(a ^ b, b, w) + sk(w, 2*i)) & m;
      b = (rl(b ^ a, a, w) + sk(w, 2*i+1)) & m;
    end
    return (b << w) | a;
  endfunction

  function automatic logic [63:0] model_dec(input int w, input int r, input logic [63:0] blk);
    logic [63:0] m, a, b;
    m = msk(w);
    a = blk & m;
    b = (blk >> w) & m;
    for (int i = r; i >= 1; i--) begin
      b = rr((b - sk(w, 2*i+1)) & m, a, w) ^ a;
      a = rr((a - sk(w, 2*i)) & m, b, w) ^ b;
    end
    b = (b - sk(w, 1)) & m;
    a = (a - sk(w, 0)) & m;
    return (b << w) | a;
  endfunction

  // Standard RC5-32 key expansion for an all-zero 16-byte key.
  task automatic keysched32_zero(input int t);
    logic [63:0] l [4];
    logic [63:0] a, b, m;
    int i, j;
    m = msk(32);
    for (int k = 0; k < T; k++) s32[k] = '0;
    for (int k = 0; k < 4; k++) l[k] = '0;
    s32[0] = 64'hB7E15163;
    for (int k = 1; k < t; k++) s32[k] = (s32[k-1] + 64'h9E3779B9) & m;
    a = '0; b = '0; i = 0; j = 0;
    for (int k = 0; k < 3 * t; k++) begin
      a = rl((s32[i] + a + b) & m, 64'd3, 32);
      s32[i] = a;
      b = rl((l[j] + a + b) & m, (a + b) & m, 32);
      l[j] = b;
      i = (i + 1) % t;
      j = (j + 1) % 4;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic        chk_en   = 1'b0;
  logic [63:0] exp32    = '0;
  logic        experr32 = 1'b0;
  logic [63:0] exp16    = '0;
  logic        experr16 = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (out_valid32) begin
        check("d_out32", d_out32, exp32);
        check("round_err32", 64'(round_err32), 64'(experr32));
      end else begin
        check("idle_out32", {d_out32[62:0], round_err32}, 64'd0);
      end
      if (out_valid16) begin
        check("d_out16", 64'(d_out16), exp16);
        check("round_err16", 64'(round_err16), 64'(experr16));
      end else begin
        check("idle_out16", 64'({d_out16, round_err16}), 64'd0);
      end
    end
  end

  // ---------------- transaction tasks ----------------
  task automatic start_op(input bit is32, input bit m, input int r, input logic [63:0] blk);
    int rc, waitc;
    rc = (r > MAXR) ? MAXR : r;
    @(negedge clk);
    waitc = 0;
    while (!(is32 ? in_ready32 : in_ready16) && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check("in_ready_before_accept", 64'(is32 ? in_ready32 : in_ready16), 64'd1);
    mode       = m;
    num_rounds = 5'(r);
    if (is32) begin
      exp32      = m ? model_dec(32, rc, blk) : model_enc(32, rc, blk);
      experr32   = (r > MAXR);
      d_in32     = blk;
      in_valid32 = 1'b1;
    end else begin
      exp16      = m ? model_dec(16, rc, blk) : model_enc(16, rc, blk);
      experr16   = (r > MAXR);
      d_in16     = blk[31:0];
      in_valid16 = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid32 = 1'b0;
    in_valid16 = 1'b0;
    mode       = ~m;
    num_rounds = 5'd7;
    d_in32     = ~d_in32;
    d_in16     = ~d_in16;
  endtask

  task automatic finish_op(input bit is32, input int hold,
                           output logic [63:0] res, output int lat, output logic err);
    lat = 1;
    @(negedge clk);
    while (!(is32 ? out_valid32 : out_valid16) && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = is32 ? d_out32 : 64'(d_out16);
    err = is32 ? round_err32 : round_err16;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_d_out", is32 ? d_out32 : 64'(d_out16), res);
      check("hold_in_ready", 64'(is32 ? in_ready32 : in_ready16), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input bit is32, input bit m, input int r, input logic [63:0] blk,
                        input int hold, output logic [63:0] res, output int lat,
                        output logic err);
    start_op(is32, m, r, blk);
    finish_op(is32, hold, res, lat, err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] res, blk, ct;
    int          lat, r;
    logic        err;

    keysched32_zero(26);
    for (int k = 0; k < T; k++) s16[k] = '0;

    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_in_ready32", 64'(in_ready32), 64'd0);
    check("reset_in_ready16", 64'(in_ready16), 64'd0);
    check("reset_out_valid", 64'({out_valid32, out_valid16}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_in_ready", 64'({in_ready32, in_ready16}), 64'd3);

    // Published RC5-32/12/16 vector, all-zero key and plaintext.
    check("model_vector_enc", model_enc(32, 12, 64'd0), 64'h6D8F4B15_EEDBA521);
    check("model_vector_dec", model_dec(32, 12, 64'h6D8F4B15_EEDBA521), 64'd0);
    run_op(1'b1, 1'b0, 12, 64'd0, 0, res, lat, err);
    check("enc32_result", res, 64'h6D8F4B15_EEDBA521);
    check("enc32_latency", 64'(lat), 64'd13);
    run_op(1'b1, 1'b1, 12, 64'h6D8F4B15_EEDBA521, 0, res, lat, err);
    check("dec32_result", res, 64'd0);
    check("dec32_round_err", 64'(err), 64'd0);
    check("dec32_latency", 64'(lat), 64'd13);

    // R=0: only the whitening step applies.
    for (int k = 0; k < T; k++) s16[k] = 64'($urandom & 32'hFFFF);
    s16[0] = 64'h0001;
    s16[1] = 64'h0002;
    check("model_r0_enc", model_enc(16, 0, 64'd0), 64'h0002_0001);
    run_op(1'b0, 1'b0, 0, 64'd0, 0, res, lat, err);
    check("enc16_r0_result", res, 64'h0002_0001);
    check("enc16_r0_latency", 64'(lat), 64'd1);
    run_op(1'b0, 1'b1, 0, 64'h0002_0001, 0, res, lat, err);
    check("dec16_r0_result", res, 64'd0);
    check("dec16_r0_latency", 64'(lat), 64'd1);

    // Random round trips on W=16.
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < T; k++) s16[k] = 64'($urandom & 32'hFFFF);
      r   = $urandom_range(0, MAXR);
      blk = 64'($urandom);
      run_op(1'b0, 1'b0, r, blk, 0, ct, lat, err);
      check("rt_enc_model", ct, model_enc(16, r, blk));
      check("rt_enc_latency", 64'(lat), 64'(r + 1));
      run_op(1'b0, 1'b1, r, ct, 0, res, lat, err);
      check("rt_dec_plain", res, blk);
      check("rt_dec_latency", 64'(lat), 64'(r + 1));
    end

    // Over-range round count clamps to MAX_ROUNDS and flags the error.
    blk = 64'h0000_0000_1234_ABCD;
    run_op(1'b0, 1'b0, 20, blk, 0, res, lat, err);
    check("clamp_result", res, model_enc(16, 16, blk));
    check("clamp_round_err", 64'(err), 64'd1);
    check("clamp_latency", 64'(lat), 64'd17);
    run_op(1'b0, 1'b0, 16, blk, 0, ct, lat, err);
    check("r16_matches_clamped", ct, res);
    check("r16_round_err", 64'(err), 64'd0);

    // Back-pressure: result held ten cycles, then released.
    blk = 64'h0000_0000_5A5A_0FF0;
    run_op(1'b0, 1'b0, 4, blk, 10, res, lat, err);
    check("hold_result", res, model_enc(16, 4, blk));
    @(negedge clk);
    check("release_in_ready", 64'(in_ready16), 64'd1);
    check("release_out_valid", 64'(out_valid16), 64'd0);

    // Reset in the middle of a long operation.
    start_op(1'b0, 1'b0, 10, 64'h0000_0000_C0DE_BEEF);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_out_valid", 64'(out_valid16), 64'd0);
    check("abort_in_ready", 64'(in_ready16), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_recover_in_ready", 64'(in_ready16), 64'd1);
    blk = 64'h0000_0000_0BAD_F00D;
    run_op(1'b0, 1'b0, 7, blk, 0, res, lat, err);
    check("after_abort_result", res, model_enc(16, 7, blk));
    check("after_abort_latency", 64'(lat), 64'd8);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
